// File: rtl/mips_cpu_top.sv
// ---------------------------------------------------------------------------
// mips_cpu_top -- single-cycle 32-bit MIPS subset CPU.
//
// Purpose:
//   Program counter, big-endian byte-addressed instruction memory, 32x32
//   register file, ALU and big-endian byte-addressed data memory. One
//   instruction commits per rising clock edge. Programs are loaded and
//   results inspected through the internal memories (my_ins_mem.memory,
//   my_reg_file.registers, my_data_mem.memory).
//
// Ports (mips_cpu_top):
//   clk  in  1  system clock, all state updates on the rising edge
//   rst  in  1  synchronous active-high reset (PC and registers cleared)
//
// Parameters:
//   IMEM_BYTES  instruction memory size in bytes (power of two)
//   DMEM_BYTES  data memory size in bytes (power of two)
// ---------------------------------------------------------------------------

// Instruction memory: read-only byte array, combinational big-endian fetch.
//   i_addr   in   AW  byte address (already reduced modulo BYTES)
//   o_instr  out  32  {mem[a], mem[a+1], mem[a+2], mem[a+3]}
module ins_mem #(
  parameter int BYTES = 256,
  parameter int AW    = 8
) (
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_instr
);
  // Contents are loaded from outside; the CPU never writes this array.
  logic [7:0] memory [0:BYTES-1];

  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;

  // AW-bit additions wrap naturally, giving the modulo-BYTES byte addresses.
  assign w_a1    = i_addr + AW'(1);
  assign w_a2    = i_addr + AW'(2);
  assign w_a3    = i_addr + AW'(3);
  assign o_instr = {memory[i_addr], memory[w_a1], memory[w_a2], memory[w_a3]};
endmodule

// Register file: 2 combinational read ports, 1 write port on the rising edge.
//   i_clk, i_rst      clock, synchronous active-high reset (clears all 32)
//   i_ra1/i_ra2       read addresses, o_rd1/o_rd2 read data
//   i_we/i_wa/i_wd    write enable, address, data
module reg_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);
  logic [31:0] registers [0:31];

  // Register update: reset clears everything, writes to $0 are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= 32'd0;
      end
    end else if (i_we && (i_wa != 5'd0)) begin
      registers[i_wa] <= i_wd;
    end
  end

  // $0 is forced to zero on read so it holds even before the first reset.
  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : registers[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : registers[i_ra2];
endmodule

// Data memory: byte array, combinational big-endian word read, edge write.
//   i_clk   clock
//   i_we    word write enable
//   i_addr  byte address modulo BYTES; unaligned words span addr..addr+3
//   i_wd    write data, o_rd read data
module data_mem #(
  parameter int BYTES = 256,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wd,
  output logic [31:0]   o_rd
);
  // Deliberately not reset: contents survive a CPU reset.
  logic [7:0] memory [0:BYTES-1];

  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;

  assign w_a1 = i_addr + AW'(1);
  assign w_a2 = i_addr + AW'(2);
  assign w_a3 = i_addr + AW'(3);
  assign o_rd = {memory[i_addr], memory[w_a1], memory[w_a2], memory[w_a3]};

  // Big-endian byte store: most significant byte at the lowest address.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      memory[i_addr] <= i_wd[31:24];
      memory[w_a1]   <= i_wd[23:16];
      memory[w_a2]   <= i_wd[15:8];
      memory[w_a3]   <= i_wd[7:0];
    end
  end
endmodule

// CPU top level.
module mips_cpu_top #(
  parameter int IMEM_BYTES = 256,
  parameter int DMEM_BYTES = 256
) (
  input  logic clk,
  input  logic rst
);
  localparam int IAW = $clog2(IMEM_BYTES);
  localparam int DAW = $clog2(DMEM_BYTES);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [31:0]    r_pc;
  logic [31:0]    w_instr;
  logic [5:0]     w_op;
  logic [4:0]     w_rs;
  logic [4:0]     w_rt;
  logic [4:0]     w_rd;
  logic [5:0]     w_funct;
  logic [15:0]    w_imm;
  logic [25:0]    w_target;
  logic [31:0]    w_sext;
  logic [31:0]    w_rs_data;
  logic [31:0]    w_rt_data;
  logic [31:0]    w_pc_plus4;
  logic [31:0]    w_br_target;
  logic [DAW-1:0] w_mem_addr;
  logic [31:0]    w_mem_rdata;
  logic           w_reg_we;
  logic [4:0]     w_reg_waddr;
  logic [31:0]    w_reg_wdata;
  logic           w_mem_we;
  logic [31:0]    w_next_pc;

  ins_mem #(.BYTES(IMEM_BYTES), .AW(IAW)) my_ins_mem (
    .i_addr  (r_pc[IAW-1:0]),
    .o_instr (w_instr)
  );

  reg_file my_reg_file (
    .i_clk (clk),
    .i_rst (rst),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rs_data),
    .o_rd2 (w_rt_data),
    .i_we  (w_reg_we),
    .i_wa  (w_reg_waddr),
    .i_wd  (w_reg_wdata)
  );

  // Stores are suppressed while reset is asserted.
  data_mem #(.BYTES(DMEM_BYTES), .AW(DAW)) my_data_mem (
    .i_clk  (clk),
    .i_we   (w_mem_we & ~rst),
    .i_addr (w_mem_addr),
    .i_wd   (w_rt_data),
    .o_rd   (w_mem_rdata)
  );

  assign w_op        = w_instr[31:26];
  assign w_rs        = w_instr[25:21];
  assign w_rt        = w_instr[20:16];
  assign w_rd        = w_instr[15:11];
  assign w_funct     = w_instr[5:0];
  assign w_imm       = w_instr[15:0];
  assign w_target    = w_instr[25:0];
  assign w_sext      = {{16{w_imm[15]}}, w_imm};
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + {w_sext[29:0], 2'b00};
  // Only the low address bits reach memory, so compute just those.
  assign w_mem_addr  = w_rs_data[DAW-1:0] + w_sext[DAW-1:0];

  // Decode and execute; unsupported opcodes/functs fall through as NOPs.
  always_comb begin
    w_reg_we    = 1'b0;
    w_reg_waddr = w_rt;
    w_reg_wdata = 32'd0;
    w_mem_we    = 1'b0;
    w_next_pc   = w_pc_plus4;
    case (w_op)
      OP_RTYPE: begin
        w_reg_waddr = w_rd;
        case (w_funct)
          FN_ADD: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rs_data + w_rt_data;
          end
          FN_SUB: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rs_data - w_rt_data;
          end
          FN_AND: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rs_data & w_rt_data;
          end
          FN_OR: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rs_data | w_rt_data;
          end
          FN_SLT: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = {31'd0, ($signed(w_rs_data) < $signed(w_rt_data))};
          end
          default: begin
            w_reg_we = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        w_reg_we    = 1'b1;
        w_reg_wdata = w_rs_data + w_sext;
      end
      OP_LW: begin
        w_reg_we    = 1'b1;
        w_reg_wdata = w_mem_rdata;
      end
      OP_SW: begin
        w_mem_we = 1'b1;
      end
      OP_BEQ: begin
        if (w_rs_data == w_rt_data) begin
          w_next_pc = w_br_target;
        end else begin
          w_next_pc = w_pc_plus4;
        end
      end
      OP_J: begin
        w_next_pc = {w_pc_plus4[31:28], w_target, 2'b00};
      end
      default: begin
        w_next_pc = w_pc_plus4;
      end
    endcase
  end

  // Program counter: reset to 0, otherwise take the decoded next PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= w_next_pc;
    end
  end
endmodule

// File: tb/tb_mips_cpu_top.sv
// Scoreboard bench for mips_cpu_top: stimulus loads programs and queues the
// expected architectural state for given cycles; a monitor on the falling
// edge pops and compares whenever an entry falls due.
module tb_mips_cpu_top;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_cpu_top #(.IMEM_BYTES(256), .DMEM_BYTES(256)) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  localparam int K_REG = 0;
  localparam int K_PC  = 1;
  localparam int K_MEM = 2;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   t0 = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t e;
  logic [31:0] act;

  // Count rising edges; an entry due at cycle N is checked after edge N.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every scoreboard entry that is due at this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_REG:   act = dut.my_reg_file.registers[e.idx];
        K_PC:    act = dut.r_pc;
        default: act = {24'd0, dut.my_data_mem.memory[e.idx]};
      endcase
      n_tests++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h (cycle %0d, due %0d)",
                 e.name, act, e.exp, cyc, e.cyc);
      end
    end
  end

  function automatic void expect_at(input string name, input int kind,
                                    input int idx, input logic [31:0] v,
                                    input int rel);
    exp_t x;
    x.name = name; x.kind = kind; x.idx = idx; x.exp = v; x.cyc = t0 + rel;
    sb.push_back(x);
  endfunction

  task automatic begin_load();
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) dut.my_ins_mem.memory[i] = 8'h00;
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    dut.my_ins_mem.memory[addr]     = w[31:24];
    dut.my_ins_mem.memory[addr + 1] = w[23:16];
    dut.my_ins_mem.memory[addr + 2] = w[15:8];
    dut.my_ins_mem.memory[addr + 3] = w[7:0];
  endtask

  // Two reset edges, then release; t0 marks the last reset edge.
  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    // ---- $0 write discarded, jump loop 0,4,0,4 ----
    begin_load();
    put_word(0, 32'h20000001);  // addi $0,$0,1
    put_word(4, 32'h08000000);  // j 0
    release_reset();
    expect_at("reset_pc", K_PC, 0, 32'd0, 0);
    expect_at("reset_r0", K_REG, 0, 32'd0, 0);
    for (int k = 1; k <= 10; k++) begin
      expect_at("loop_pc", K_PC, 0, (k % 2 == 1) ? 32'd4 : 32'd0, k);
    end
    expect_at("loop_r0", K_REG, 0, 32'd0, 10);
    repeat (10) @(posedge clk);

    // ---- ALU: addi/add/sub/and/or/slt and an unsupported funct ----
    begin_load();
    put_word(0,  32'h20010005);  // addi $1,$0,5
    put_word(4,  32'h2002FFFD);  // addi $2,$0,-3
    put_word(8,  32'h00221820);  // add  $3,$1,$2
    put_word(12, 32'h00222022);  // sub  $4,$1,$2
    put_word(16, 32'h00224024);  // and  $8,$1,$2
    put_word(20, 32'h00224825);  // or   $9,$1,$2
    put_word(24, 32'h0041282A);  // slt  $5,$2,$1
    put_word(28, 32'h0022302A);  // slt  $6,$1,$2
    put_word(32, 32'h00221827);  // nor  $3,$1,$2 (unsupported -> NOP)
    release_reset();
    expect_at("addi_r1", K_REG, 1, 32'd5, 3);
    expect_at("addi_r2", K_REG, 2, 32'hFFFFFFFD, 3);
    expect_at("add_r3",  K_REG, 3, 32'd2, 3);
    expect_at("sub_r4",  K_REG, 4, 32'd8, 9);
    expect_at("and_r8",  K_REG, 8, 32'h00000005, 9);
    expect_at("or_r9",   K_REG, 9, 32'hFFFFFFFD, 9);
    expect_at("slt_r5",  K_REG, 5, 32'd1, 9);
    expect_at("slt_r6",  K_REG, 6, 32'd0, 9);
    expect_at("nop_r3",  K_REG, 3, 32'd2, 10);
    expect_at("nop_pc",  K_PC, 0, 32'd40, 10);
    repeat (10) @(posedge clk);

    // ---- Memory: build 0x12345678, sw/lw aligned and wrapping ----
    begin_load();
    put_word(0, 32'h20011234);               // addi $1,$0,0x1234
    for (int i = 0; i < 16; i++)
      put_word(4 + 4 * i, 32'h00210820);     // add $1,$1,$1
    put_word(68, 32'h20215678);              // addi $1,$1,0x5678
    put_word(72, 32'hAC010008);              // sw $1,8($0)
    put_word(76, 32'h8C070008);              // lw $7,8($0)
    put_word(80, 32'hAC01FFFE);              // sw $1,-2($0) -> bytes 254,255,0,1
    release_reset();
    expect_at("build_r1", K_REG, 1, 32'h12345678, 18);
    expect_at("sw_b8",  K_MEM, 8,  32'h12, 19);
    expect_at("sw_b9",  K_MEM, 9,  32'h34, 19);
    expect_at("sw_b10", K_MEM, 10, 32'h56, 19);
    expect_at("sw_b11", K_MEM, 11, 32'h78, 19);
    expect_at("lw_r7",  K_REG, 7, 32'h12345678, 20);
    expect_at("wrap_b254", K_MEM, 254, 32'h12, 21);
    expect_at("wrap_b255", K_MEM, 255, 32'h34, 21);
    expect_at("wrap_b0",   K_MEM, 0,   32'h56, 21);
    expect_at("wrap_b1",   K_MEM, 1,   32'h78, 21);
    repeat (21) @(posedge clk);

    // ---- beq taken / not taken / self loop ----
    begin_load();
    put_word(0,  32'h20010007);  // addi $1,$0,7
    put_word(4,  32'h20020007);  // addi $2,$0,7
    put_word(8,  32'h10220002);  // beq $1,$2,2 -> 20
    put_word(12, 32'h20030001);  // addi $3,$0,1 (skipped)
    put_word(16, 32'h20030002);  // addi $3,$0,2 (skipped)
    put_word(20, 32'h10200005);  // beq $1,$0,5 (not taken)
    put_word(24, 32'h20040009);  // addi $4,$0,9
    put_word(28, 32'h1000FFFF);  // beq $0,$0,-1 (self loop)
    release_reset();
    expect_at("beq_taken_pc", K_PC, 0, 32'd20, 3);
    expect_at("beq_nt_pc",    K_PC, 0, 32'd24, 4);
    expect_at("after_nt_pc",  K_PC, 0, 32'd28, 5);
    expect_at("after_nt_r4",  K_REG, 4, 32'd9, 5);
    expect_at("selfloop_pc6", K_PC, 0, 32'd28, 6);
    expect_at("selfloop_pc8", K_PC, 0, 32'd28, 8);
    expect_at("skipped_r3",   K_REG, 3, 32'd0, 8);
    repeat (8) @(posedge clk);

    // ---- Reset mid-run overrides the in-flight instruction ----
    begin_load();
    put_word(0, 32'h20010055);  // addi $1,$0,0x55
    put_word(4, 32'h20020003);  // addi $2,$0,3 (killed by reset)
    put_word(8, 32'h08000000);  // j 0
    release_reset();
    expect_at("pre_rst_r1", K_REG, 1, 32'h55, 1);
    expect_at("pre_rst_pc", K_PC, 0, 32'd4, 1);
    expect_at("mid_rst_pc", K_PC, 0, 32'd0, 2);
    expect_at("mid_rst_r1", K_REG, 1, 32'd0, 2);
    expect_at("mid_rst_r2", K_REG, 2, 32'd0, 2);
    expect_at("dmem_kept",  K_MEM, 8, 32'h12, 2);
    expect_at("rerun_r1",   K_REG, 1, 32'h55, 3);
    expect_at("rerun_r2",   K_REG, 2, 32'd0, 3);
    expect_at("rerun_pc",   K_PC, 0, 32'd4, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      $display("FAIL drain: actual %0d pending entries required 0", sb.size());
      n_fail += sb.size();
      n_tests += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
